// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decoder
// Description : Two-stage RV32I ALU-op decode pipeline. S1 decodes the
//               instruction into ALU operands/opcode, and S2 registers the
//               returned ALU result for writeback. Ready/valid on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_result,
    output logic        out_illegal,
    output logic [15:0] illegal_count
);

    localparam logic [3:0]  c_op_add = 4'b0000;
    localparam logic [3:0]  c_op_sub = 4'b0001;
    localparam logic [3:0]  c_op_and = 4'b0010;
    localparam logic [3:0]  c_op_or  = 4'b0011;
    localparam logic [3:0]  c_op_xor = 4'b0100;
    localparam logic [3:0]  c_op_ill = 4'b1111;
    localparam logic [6:0]  c_opc_reg = 7'b0110011;
    localparam logic [6:0]  c_opc_imm = 7'b0010011;
    localparam logic [6:0]  c_f7_base = 7'b0000000;
    localparam logic [6:0]  c_f7_alt  = 7'b0100000;
    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic        r_s1_valid;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [3:0]  r_alu_op;
    logic [4:0]  r_s1_rd;
    logic        r_s1_illegal;
    logic        r_out_valid;
    logic [4:0]  r_out_rd;
    logic [31:0] r_out_result;
    logic        r_out_illegal;
    logic [15:0] r_illegal_count;

    logic        w_s2_free;
    logic        w_s1_free;
    logic        w_in_fire;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm;
    logic        w_legal;
    logic [3:0]  w_op;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_unused;

    assign w_s2_free = !r_out_valid || out_ready;
    assign w_s1_free = !r_s1_valid || w_s2_free;
    assign w_in_fire = in_valid && w_s1_free;
    assign in_ready  = w_s1_free;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_imm    = {{20{in_instr[31]}}, in_instr[31:20]};
    // rs1/rs2 index fields are not needed: operand values arrive pre-read.
    assign w_unused = ^in_instr[19:15];

    always_comb begin
        w_legal = 1'b0;
        w_op    = c_op_ill;
        w_b     = '0;
        if (w_opcode == c_opc_reg && w_funct7 == c_f7_base) begin
            w_legal = 1'b1;
            w_b     = in_rs2_val;
            case (w_funct3)
                3'b000:  w_op = c_op_add;
                3'b100:  w_op = c_op_xor;
                3'b110:  w_op = c_op_or;
                3'b111:  w_op = c_op_and;
                default: w_legal = 1'b0;
            endcase
        end else if (w_opcode == c_opc_reg && w_funct7 == c_f7_alt && w_funct3 == 3'b000) begin
            w_legal = 1'b1;
            w_op    = c_op_sub;
            w_b     = in_rs2_val;
        end else if (w_opcode == c_opc_imm) begin
            w_legal = 1'b1;
            w_b     = w_imm;
            case (w_funct3)
                3'b000:  w_op = c_op_add;
                3'b100:  w_op = c_op_xor;
                3'b110:  w_op = c_op_or;
                3'b111:  w_op = c_op_and;
                default: w_legal = 1'b0;
            endcase
        end
        // Unsupported funct3 falls through here too, so zero everything once.
        if (!w_legal) begin
            w_op = c_op_ill;
            w_b  = '0;
        end
        w_a = w_legal ? in_rs1_val : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid      <= 1'b0;
            r_alu_a         <= '0;
            r_alu_b         <= '0;
            r_alu_op        <= c_op_add;
            r_s1_rd         <= '0;
            r_s1_illegal    <= 1'b0;
            r_illegal_count <= '0;
        end else begin
            if (w_s1_free) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_fire) begin
                r_alu_a      <= w_a;
                r_alu_b      <= w_b;
                r_alu_op     <= w_op;
                r_s1_rd      <= in_instr[11:7];
                r_s1_illegal <= !w_legal;
                if (!w_legal && r_illegal_count != c_cnt_max) begin
                    r_illegal_count <= r_illegal_count + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_rd      <= '0;
            r_out_result  <= '0;
            r_out_illegal <= 1'b0;
        end else if (w_s2_free) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_rd      <= r_s1_rd;
                r_out_illegal <= r_s1_illegal;
                // Writes to x0 and illegal bundles carry a zero result.
                r_out_result  <= (r_s1_illegal || r_s1_rd == 5'd0) ? 32'd0 : alu_result;
            end
        end
    end

    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_op        = r_alu_op;
    assign out_valid     = r_out_valid;
    assign out_rd        = r_out_rd;
    assign out_result    = r_out_result;
    assign out_illegal   = r_out_illegal;
    assign illegal_count = r_illegal_count;

endmodule
`default_nettype wire
